qnn_requant_stream: RTL and testbench
=====================================

Name: qnn_requant_stream

Overview:
- Downstream stage of the QNN accelerator core; consumes its OUT_DIM x 32-bit accumulator array when the core pulses done.
- Requantises each channel: multiply, rounding right-shift, optional ReLU, saturation to the layer precision (INT8/INT4/BIN).
- Streams results one channel per beat over a valid/ready interface to the next layer's input buffer.

Parameters:
- OUT_DIM, 16, number of accumulator channels captured and streamed per layer.
- ACC_W, 32, signed accumulator width.
- MULT_W, 16, signed requant multiplier width.
- SHIFT_W, 5, requant right-shift amount width (0..31).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- acc_done  in  1  one-cycle pulse from the accelerator core; acc_out valid in that cycle.
- acc_out  in  [OUT_DIM] x ACC_W signed  accumulator results.
- layer_prec  in  2  00=INT8, 01=INT4, 10=BIN, 11=treated as INT8.
- requant_mult  in  MULT_W signed  per-layer multiplier.
- requant_shift  in  SHIFT_W  per-layer right-shift.
- relu_en  in  1  clamp negatives to 0 before saturation.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  8 signed  requantised value (INT4 sign-extended; BIN in bit 0).
- m_idx  out  $clog2(OUT_DIM)  channel index of current beat.
- m_last  out  1  high with the beat for channel OUT_DIM-1.
- busy  out  1  high from capture until the last beat handshakes.
- overrun  out  1  sticky: acc_done arrived while busy.

Behaviour:
- Reset (async, rst_n low): m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, overrun=0, FSM=IDLE, pipeline stages invalid. Reset mid-stream discards all remaining channels; no partial output follows.
- FSM: IDLE -> RUN on acc_done. RUN -> IDLE on the edge where the OUT_DIM-1 beat handshakes (m_valid & m_ready).
- Capture: on the acc_done edge in IDLE, copy acc_out, layer_prec, requant_mult, requant_shift and relu_en into shadow registers. busy=1 from that edge. Configuration inputs are ignored afterwards until the next capture.
- Pipeline, per channel, in index order 0..OUT_DIM-1:
  - S1: prod = acc*mult, ACC_W+MULT_W bits signed, registered.
  - S2: round/shift/relu/saturate into the output register (m_data/m_idx/m_last).
- Latency: channel 0 appears with m_valid=1 after the 2nd rising edge following the capture edge.
- Throughput: 1 beat/cycle while m_ready=1.
- Backpressure: the pipeline advances only when (!m_valid | m_ready). While m_valid & !m_ready, m_data, m_idx and m_last are held stable and S1 holds. No channel is dropped or duplicated.
- Rounding: shift=0 passes prod unchanged. shift>0 computes (prod + (1<<(shift-1))) >>> shift, arithmetic, at full width, with no overflow before saturation.
- ReLU: if relu_en and r<0, r=0.
- Saturation by precision:
  - INT8: clamp to [-128,127].
  - INT4: clamp to [-8,7], sign-extended to 8 bits.
  - BIN: m_data = 1 if r>=0, else 0; bits 7:1 are 0.
- acc_done while busy, including the final-handshake cycle: ignored, overrun<=1, stream unaffected. overrun clears only on reset.
- busy falls on the final handshake edge. The next acc_done is accepted from the following cycle.

Test Plan:
- INT8, mult=3, shift=2, relu off, acc[0]=10, acc[1]=-10 -> m_data 8 then -7, m_idx 0 then 1. m_ready=1 throughout -> 16 beats in 16 consecutive cycles, m_last only on idx 15.
- Saturation, mult=1, shift=0: INT8 with acc=100000 / -100000 -> 127 / -128. INT4 with acc=20 / -20 -> 7 / -8 (0xF8).
- relu_en=1, INT8, acc=-5 -> 0. BIN with relu off: acc=0 -> 1, acc=-1 -> 0.
- m_ready low for 5 cycles while idx 3 is presented -> m_data and m_idx held constant. After release, idx 4..15 follow with no loss, and the captured values are unchanged even though acc_out changes during the stream.
- acc_done pulsed at idx 6 -> overrun=1 (sticky), stream completes with original data, busy falls after the idx 15 handshake. A new acc_done one cycle later is accepted normally.
- rst_n low while idx 7 is valid -> all outputs at reset values asynchronously. The next acc_done after release restarts the stream at idx 0 with the newly captured data.

Source files
------------

// File: rtl/qnn_requant_stream.sv
`default_nettype none
// qnn_requant_stream: captures the accumulator vector on acc_done, then streams each channel
// through multiply -> rounding shift -> ReLU -> saturation over a valid/ready port.
module qnn_requant_stream #(
  parameter int OUT_DIM = 16,
  parameter int ACC_W   = 32,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          acc_done,
  input  logic [OUT_DIM-1:0][ACC_W-1:0] acc_out,
  input  logic [1:0]                    layer_prec,
  input  logic signed [MULT_W-1:0]      requant_mult,
  input  logic [SHIFT_W-1:0]            requant_shift,
  input  logic                          relu_en,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [7:0]             m_data,
  output logic [$clog2(OUT_DIM)-1:0]    m_idx,
  output logic                          m_last,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W  = $clog2(OUT_DIM);
  localparam int PROD_W = ACC_W + MULT_W;
  localparam int RND_W  = PROD_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_DIM - 1);
  localparam logic [1:0] PREC_INT4 = 2'b01;
  localparam logic [1:0] PREC_BIN  = 2'b10;
  localparam logic signed [RND_W-1:0] I8_MAX = RND_W'(127);
  localparam logic signed [RND_W-1:0] I8_MIN = -RND_W'(128);
  localparam logic signed [RND_W-1:0] I4_MAX = RND_W'(7);
  localparam logic signed [RND_W-1:0] I4_MIN = -RND_W'(8);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [OUT_DIM-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [1:0]                    prec_q, prec_d;
  logic signed [MULT_W-1:0]      mult_q, mult_d;
  logic [SHIFT_W-1:0]            shift_q, shift_d;
  logic                          relu_q, relu_d;

  // issue_q: channels still waiting to enter S1; rd_idx_q is the next one.
  logic                          issue_q, issue_d;
  logic [IDX_W-1:0]              rd_idx_q, rd_idx_d;

  logic                          s1_valid_q, s1_valid_d;
  logic signed [PROD_W-1:0]      s1_prod_q, s1_prod_d;
  logic [IDX_W-1:0]              s1_idx_q, s1_idx_d;

  logic                          m_valid_q, m_valid_d;
  logic signed [7:0]             m_data_q, m_data_d;
  logic [IDX_W-1:0]              m_idx_q, m_idx_d;
  logic                          m_last_q, m_last_d;
  logic                          overrun_q, overrun_d;

  logic                          advance;
  logic                          final_hs;
  logic signed [ACC_W-1:0]       acc_sel;
  logic signed [RND_W-1:0]       wide;
  logic signed [RND_W-1:0]       rnd;
  logic signed [7:0]             sat;

  // S2 datapath: one extra bit of headroom keeps the rounding add exact.
  always_comb begin
    wide = {s1_prod_q[PROD_W-1], s1_prod_q};
    rnd  = RND_W'(1) << (shift_q - 1'b1);
    if (shift_q != '0) begin
      wide = (wide + rnd) >>> shift_q;
    end
    if (relu_q && wide[RND_W-1]) begin
      wide = '0;
    end
    sat = wide[7:0];
    case (prec_q)
      PREC_INT4: begin
        if (wide > I4_MAX)      sat = 8'sd7;
        else if (wide < I4_MIN) sat = -8'sd8;
        else                    sat = wide[7:0];
      end
      PREC_BIN: sat = {7'b0, ~wide[RND_W-1]};
      default: begin
        if (wide > I8_MAX)      sat = 8'sd127;
        else if (wide < I8_MIN) sat = -8'sd128;
        else                    sat = wide[7:0];
      end
    endcase
  end

  assign acc_sel  = acc_q[rd_idx_q];
  assign advance  = !m_valid_q || m_ready;
  assign final_hs = m_valid_q && m_ready && m_last_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    prec_d     = prec_q;
    mult_d     = mult_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    issue_d    = issue_q;
    rd_idx_d   = rd_idx_q;
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_idx_d   = s1_idx_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_idx_d    = m_idx_q;
    m_last_d   = m_last_q;
    overrun_d  = overrun_q;

    case (state_q)
      IDLE: begin
        if (acc_done) begin
          state_d  = RUN;
          acc_d    = acc_out;
          prec_d   = layer_prec;
          mult_d   = requant_mult;
          shift_d  = requant_shift;
          relu_d   = relu_en;
          issue_d  = 1'b1;
          rd_idx_d = '0;
        end
      end
      RUN: begin
        if (acc_done) overrun_d = 1'b1;
        if (final_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      s1_valid_d = issue_q;
      if (issue_q) begin
        s1_prod_d = PROD_W'(acc_sel) * PROD_W'(mult_q);
        s1_idx_d  = rd_idx_q;
        rd_idx_d  = rd_idx_q + 1'b1;
        if (rd_idx_q == LAST_IDX) issue_d = 1'b0;
      end
      m_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        m_data_d = sat;
        m_idx_d  = s1_idx_q;
        m_last_d = (s1_idx_q == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      prec_q     <= '0;
      mult_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      issue_q    <= 1'b0;
      rd_idx_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_idx_q   <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_idx_q    <= '0;
      m_last_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      prec_q     <= prec_d;
      mult_q     <= mult_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      issue_q    <= issue_d;
      rd_idx_q   <= rd_idx_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_idx_q   <= s1_idx_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_idx_q    <= m_idx_d;
      m_last_q   <= m_last_d;
      overrun_q  <= overrun_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_idx   = m_idx_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q == RUN);
  assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_qnn_requant_stream.sv
`default_nettype none
// tb_qnn_requant_stream: directed vectors with hand-computed expectations for the
// requantisation stream (rounding, saturation, backpressure, overrun, async reset).
module tb_qnn_requant_stream;

  localparam int OUT_DIM = 16;
  localparam int ACC_W   = 32;
  localparam int MULT_W  = 16;
  localparam int SHIFT_W = 5;

  logic                          clk;
  logic                          rst_n;
  logic                          acc_done;
  logic [OUT_DIM-1:0][ACC_W-1:0] acc_vec;
  logic [1:0]                    layer_prec;
  logic signed [MULT_W-1:0]      requant_mult;
  logic [SHIFT_W-1:0]            requant_shift;
  logic                          relu_en;
  logic                          m_valid;
  logic                          m_ready;
  logic signed [7:0]             m_data;
  logic [3:0]                    m_idx;
  logic                          m_last;
  logic                          busy;
  logic                          overrun;

  int n_checks = 0;
  int n_err    = 0;
  logic signed [7:0] exp_data [OUT_DIM];

  qnn_requant_stream #(
    .OUT_DIM(OUT_DIM), .ACC_W(ACC_W), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_done     (acc_done),
    .acc_out      (acc_vec),
    .layer_prec   (layer_prec),
    .requant_mult (requant_mult),
    .requant_shift(requant_shift),
    .relu_en      (relu_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_idx        (m_idx),
    .m_last       (m_last),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
    end
  endtask

  // Pulse acc_done for one edge, then scramble every input the shadow copy must ignore.
  task automatic capture(input string tag);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    for (int i = 0; i < OUT_DIM; i++) acc_vec[i] = $urandom;
    layer_prec    = 2'($urandom);
    requant_mult  = 16'($urandom);
    requant_shift = 5'($urandom);
    relu_en       = 1'($urandom);
    check({tag, " busy@capture"}, 32'(busy), 32'd1);
    check({tag, " valid@capture"}, 32'(m_valid), 32'd0);
  endtask

  // Follows the beats after capture; optionally stalls at one index and pulses acc_done at one.
  task automatic run_stream(input string tag, input int stall_at, input int stall_n,
                            input int pulse_at);
    tick();
    check({tag, " latency"}, 32'(m_valid), 32'd0);
    for (int i = 0; i < OUT_DIM; i++) begin
      tick();
      acc_done = 1'b0;
      check($sformatf("%s valid[%0d]", tag, i), 32'(m_valid), 32'd1);
      check($sformatf("%s idx[%0d]", tag, i), 32'(m_idx), 32'(i));
      check($sformatf("%s data[%0d]", tag, i), 32'(m_data), 32'(exp_data[i]));
      check($sformatf("%s last[%0d]", tag, i), 32'(m_last), 32'(i == OUT_DIM - 1));
      if (i == stall_at) begin
        m_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          tick();
          check($sformatf("%s hold idx c%0d", tag, k), 32'(m_idx), 32'(i));
          check($sformatf("%s hold data c%0d", tag, k), 32'(m_data), 32'(exp_data[i]));
          check($sformatf("%s hold valid c%0d", tag, k), 32'(m_valid), 32'd1);
        end
        m_ready = 1'b1;
      end
      if (i == pulse_at) acc_done = 1'b1;
    end
    tick();
    acc_done = 1'b0;
    check({tag, " busy@end"}, 32'(busy), 32'd0);
    check({tag, " valid@end"}, 32'(m_valid), 32'd0);
  endtask

  task automatic set_cfg(input logic [1:0] prec, input int mult, input int shift,
                         input logic relu);
    layer_prec    = prec;
    requant_mult  = 16'(mult);
    requant_shift = 5'(shift);
    relu_en       = relu;
  endtask

  initial begin
    rst_n    = 1'b0;
    acc_done = 1'b0;
    m_ready  = 1'b1;
    acc_vec  = '0;
    set_cfg(2'b00, 1, 0, 1'b0);
    tick();
    tick();
    check("rst valid", 32'(m_valid), 32'd0);
    check("rst data", 32'(m_data), 32'd0);
    check("rst idx", 32'(m_idx), 32'd0);
    check("rst last", 32'(m_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // INT8, mult=3, shift=2: (3*acc + 2) >>> 2
    for (int i = 0; i < OUT_DIM; i++) begin
      acc_vec[i]  = 32'(4 * i);
      exp_data[i] = 8'(3 * i);
    end
    acc_vec[0] = 32'(10);  exp_data[0] = 8'sd8;
    acc_vec[1] = -32'sd10; exp_data[1] = -8'sd7;
    set_cfg(2'b00, 3, 2, 1'b0);
    capture("int8");
    run_stream("int8", -1, 0, -1);
    check("int8 overrun", 32'(overrun), 32'd0);

    // INT8 saturation
    for (int i = 0; i < OUT_DIM; i++) begin acc_vec[i] = '0; exp_data[i] = '0; end
    acc_vec[0] = 32'(100000);   exp_data[0] = 8'sd127;
    acc_vec[1] = -32'sd100000;  exp_data[1] = -8'sd128;
    acc_vec[2] = 32'(-100);     exp_data[2] = -8'sd100;
    set_cfg(2'b00, 1, 0, 1'b0);
    capture("sat8");
    run_stream("sat8", -1, 0, -1);

    // INT4 saturation, sign-extended
    for (int i = 0; i < OUT_DIM; i++) begin acc_vec[i] = 32'(3); exp_data[i] = 8'sd3; end
    acc_vec[0] = 32'(20);  exp_data[0] = 8'sd7;
    acc_vec[1] = -32'sd20; exp_data[1] = -8'sd8;
    acc_vec[2] = -32'sd3;  exp_data[2] = -8'sd3;
    set_cfg(2'b01, 1, 0, 1'b0);
    capture("sat4");
    run_stream("sat4", -1, 0, -1);

    // ReLU on INT8
    for (int i = 0; i < OUT_DIM; i++) begin acc_vec[i] = '0; exp_data[i] = '0; end
    acc_vec[0] = -32'sd5; exp_data[0] = 8'sd0;
    acc_vec[1] = 32'(5);  exp_data[1] = 8'sd5;
    set_cfg(2'b00, 1, 0, 1'b1);
    capture("relu");
    run_stream("relu", -1, 0, -1);

    // BIN, relu off
    for (int i = 0; i < OUT_DIM; i++) begin acc_vec[i] = -32'sd7; exp_data[i] = 8'sd0; end
    acc_vec[0] = '0;      exp_data[0] = 8'sd1;
    acc_vec[1] = -32'sd1; exp_data[1] = 8'sd0;
    acc_vec[2] = 32'(5);  exp_data[2] = 8'sd1;
    set_cfg(2'b10, 1, 0, 1'b0);
    capture("bin");
    run_stream("bin", -1, 0, -1);

    // precision code 11 behaves as INT8
    for (int i = 0; i < OUT_DIM; i++) begin acc_vec[i] = '0; exp_data[i] = '0; end
    acc_vec[0] = 32'(200); exp_data[0] = 8'sd127;
    acc_vec[1] = 32'(100); exp_data[1] = 8'sd100;
    set_cfg(2'b11, 1, 0, 1'b0);
    capture("prec3");
    run_stream("prec3", -1, 0, -1);

    // Backpressure: 5-cycle stall while idx 3 is presented
    for (int i = 0; i < OUT_DIM; i++) begin
      acc_vec[i]  = 32'(4 * i);
      exp_data[i] = 8'(3 * i);
    end
    acc_vec[0] = 32'(10);  exp_data[0] = 8'sd8;
    acc_vec[1] = -32'sd10; exp_data[1] = -8'sd7;
    set_cfg(2'b00, 3, 2, 1'b0);
    capture("bp");
    run_stream("bp", 3, 5, -1);

    // Overrun: acc_done pulsed at idx 6; shift=4 gives (16*i + 8) >>> 4 = i
    for (int i = 0; i < OUT_DIM; i++) begin acc_vec[i] = 32'(16 * i); exp_data[i] = 8'(i); end
    set_cfg(2'b00, 1, 4, 1'b0);
    capture("ovr");
    run_stream("ovr", -1, 0, 6);
    check("ovr sticky", 32'(overrun), 32'd1);

    // Next acc_done the cycle after busy falls is accepted: mult=-1 gives -i
    for (int i = 0; i < OUT_DIM; i++) begin acc_vec[i] = 32'(i); exp_data[i] = 8'(-i); end
    set_cfg(2'b00, -1, 0, 1'b0);
    capture("next");
    run_stream("next", -1, 0, -1);
    check("next overrun", 32'(overrun), 32'd1);

    // Async reset while idx 7 is valid
    for (int i = 0; i < OUT_DIM; i++) begin acc_vec[i] = 32'(16 * i); exp_data[i] = 8'(i); end
    set_cfg(2'b00, 1, 4, 1'b0);
    capture("mrst");
    tick();
    for (int i = 0; i < 8; i++) tick();
    check("mrst idx7", 32'(m_idx), 32'd7);
    rst_n = 1'b0;
    #2;
    check("mrst valid", 32'(m_valid), 32'd0);
    check("mrst data", 32'(m_data), 32'd0);
    check("mrst idx", 32'(m_idx), 32'd0);
    check("mrst last", 32'(m_last), 32'd0);
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst overrun", 32'(overrun), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mrst quiet valid c%0d", k), 32'(m_valid), 32'd0);
      check($sformatf("mrst quiet busy c%0d", k), 32'(busy), 32'd0);
    end

    // Restart with new data: (-16*i + 8) >>> 4 = -i
    for (int i = 0; i < OUT_DIM; i++) begin acc_vec[i] = 32'(-16 * i); exp_data[i] = 8'(-i); end
    set_cfg(2'b00, 1, 4, 1'b0);
    capture("rest");
    run_stream("rest", -1, 0, -1);
    check("rest overrun", 32'(overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
